// File: rtl/encoder_8x3_sched.sv
// Sequential 8-to-3 priority encoder: captures a request vector and hands out one index per handshake.
// Optional build macro ENC_MERGE_EN lets new requests merge into the pending set while serving.
module encoder_8x3_sched #(
  parameter int PRIO_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic       load,
  input  logic [7:0] D,
  output logic [2:0] A,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] pending
);

  typedef enum logic {IDLE, SERVE} state_t;
  state_t state;

  // Scan in rising priority so the last set bit seen is the winner.
  function automatic logic [2:0] enc(input logic [7:0] x);
    logic [2:0] r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = (PRIO_HIGH != 0) ? k : 7 - k;
      if (x[idx]) r = idx[2:0];
    end
    return r;
  endfunction

  logic       accept;
  logic       update;
  logic [7:0] served;
  logic [7:0] nxt;
`ifdef ENC_MERGE_EN
  logic       merge;
`endif

  always_comb begin
    accept = (state == SERVE) && E && valid && ready;
    served = accept ? (pending & ~(8'b1 << A)) : pending;
`ifdef ENC_MERGE_EN
    merge  = (state == SERVE) && E && load;
    nxt    = served | (merge ? D : '0);
    update = accept || merge;
`else
    nxt    = served;
    update = accept;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      A       <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (E) begin
        unique case (state)
          IDLE: begin
            if (load) begin
              pending <= D;
              A       <= enc(D);
              valid   <= |D;
              if (|D) state <= SERVE;
            end
          end
          SERVE: begin
            if (update) begin
              pending <= nxt;
              // A only advances on an accept; a merge alone keeps the offered code.
              if (accept) begin
                A     <= enc(nxt);
                valid <= |nxt;
              end
              if (nxt == '0) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign busy = (state == SERVE);

endmodule

// File: tb/tb_encoder_8x3_sched.sv
// Scoreboard bench: both priority orders run side by side on shared stimulus.
module tb_encoder_8x3_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       E = 1'b0;
  logic       load = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] D = '0;

  logic [2:0] a_hi, a_lo;
  logic       valid_hi, valid_lo, busy_hi, busy_lo, done_hi, done_lo;
  logic [7:0] pend_hi, pend_lo;

  always #5 clk = ~clk;

  encoder_8x3_sched #(.PRIO_HIGH(1)) dut_hi (
    .clk(clk), .rst(rst), .E(E), .load(load), .D(D), .A(a_hi), .valid(valid_hi),
    .ready(ready), .busy(busy_hi), .done(done_hi), .pending(pend_hi)
  );

  encoder_8x3_sched #(.PRIO_HIGH(0)) dut_lo (
    .clk(clk), .rst(rst), .E(E), .load(load), .D(D), .A(a_lo), .valid(valid_lo),
    .ready(ready), .busy(busy_lo), .done(done_lo), .pending(pend_lo)
  );

  // Expected codes still to be served, in service order.
  int q_hi[$];
  int q_lo[$];
  bit serve = 1'b0;
  bit exp_done = 1'b0;
  bit chk_en = 1'b0;
  int tests = 0;
  int fails = 0;

  function automatic int ord(bit hi, int k);
    return hi ? 7 - k : k;
  endfunction

  function automatic logic [7:0] bits_of(bit hi);
    logic [7:0] s;
    s = '0;
    if (hi) foreach (q_hi[i]) s[q_hi[i]] = 1'b1;
    else    foreach (q_lo[i]) s[q_lo[i]] = 1'b1;
    return s;
  endfunction

  task automatic rebuild(input bit hi, input logic [7:0] s_in, input bit keep_front);
    logic [7:0] s;
    int f;
    int idx;
    bit keep;
    s = s_in;
    keep = keep_front && (hi ? q_hi.size() != 0 : q_lo.size() != 0);
    f = 0;
    if (keep) begin
      f = hi ? q_hi[0] : q_lo[0];
      s[f] = 1'b0;
    end
    if (hi) q_hi.delete(); else q_lo.delete();
    if (keep) begin
      if (hi) q_hi.push_back(f); else q_lo.push_back(f);
    end
    for (int k = 0; k < 8; k++) begin
      idx = ord(hi, k);
      if (s[idx]) begin
        if (hi) q_hi.push_back(idx); else q_lo.push_back(idx);
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_hi", {7'b0, valid_hi}, {7'b0, q_hi.size() != 0});
      chk("busy_hi", {7'b0, busy_hi}, {7'b0, serve});
      chk("done_hi", {7'b0, done_hi}, {7'b0, exp_done});
      chk("pending_hi", pend_hi, bits_of(1'b1));
      chk("A_hi", {5'b0, a_hi}, (q_hi.size() != 0) ? 8'(q_hi[0]) : 8'h00);
      chk("valid_lo", {7'b0, valid_lo}, {7'b0, q_lo.size() != 0});
      chk("busy_lo", {7'b0, busy_lo}, {7'b0, serve});
      chk("done_lo", {7'b0, done_lo}, {7'b0, exp_done});
      chk("pending_lo", pend_lo, bits_of(1'b0));
      chk("A_lo", {5'b0, a_lo}, (q_lo.size() != 0) ? 8'(q_lo[0]) : 8'h00);
      if (!rst && E && ready && valid_hi && q_hi.size() != 0) void'(q_hi.pop_front());
      if (!rst && E && ready && valid_lo && q_lo.size() != 0) void'(q_lo.pop_front());
    end
  end

  task automatic step(input logic r_, input logic e_, input logic l_, input logic rd_,
                      input logic [7:0] d_);
    bit was;
    rst = r_; E = e_; load = l_; ready = rd_; D = d_;
    @(posedge clk);
    was = serve;
    exp_done = 1'b0;
    if (r_) begin
      q_hi.delete();
      q_lo.delete();
    end else if (e_) begin
      if (!was && l_) begin
        rebuild(1'b1, d_, 1'b0);
        rebuild(1'b0, d_, 1'b0);
      end
`ifdef ENC_MERGE_EN
      else if (was && l_) begin
        rebuild(1'b1, bits_of(1'b1) | d_, !rd_);
        rebuild(1'b0, bits_of(1'b0) | d_, !rd_);
      end
`endif
      if (was && rd_ && q_hi.size() == 0) exp_done = 1'b1;
    end
    serve = (q_hi.size() != 0);
    #1;
  endtask

  initial begin
    step(1, 0, 0, 0, 8'h00);
    chk_en = 1'b1;
    step(1, 1, 1, 1, 8'hFF);
    // Descending and ascending service of A4 under continuous ready.
    step(0, 1, 1, 1, 8'hA4);
    repeat (4) step(0, 1, 0, 1, 8'h00);
    // Backpressure holds the offered code.
    step(0, 1, 1, 0, 8'h81);
    repeat (3) step(0, 1, 0, 0, 8'h00);
    repeat (3) step(0, 1, 0, 1, 8'h00);
    // Enable low freezes the handshake even with ready high.
    step(0, 1, 1, 1, 8'hA4);
    step(0, 1, 0, 1, 8'h00);
    repeat (2) step(0, 0, 0, 1, 8'h00);
    repeat (3) step(0, 1, 0, 1, 8'h00);
    // Empty load, then reset in the middle of a full vector.
    step(0, 1, 1, 1, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    step(0, 1, 1, 1, 8'hFF);
    repeat (2) step(0, 1, 0, 1, 8'h00);
    step(1, 1, 0, 1, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    // Load during serve alongside the accept of the held code.
    step(0, 1, 1, 0, 8'h10);
    step(0, 1, 1, 1, 8'h02);
    repeat (3) step(0, 1, 0, 1, 8'h00);
    // Merge without accept, then drain.
    step(0, 1, 1, 0, 8'h24);
    step(0, 1, 1, 0, 8'h81);
    repeat (6) step(0, 1, 0, 1, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) >= 10,
           ($urandom % 4) == 0, ($urandom % 3) != 0, 8'($urandom));
    end
    repeat (10) step(0, 1, 0, 1, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
